// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
// Holds the default bus widths and the hardwired-zero register index.
package regfile_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned ZERO_IDX       = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Tracks registers awaiting a writeback and keeps a registered count of them.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit          ZERO_REG   = 1'b1,
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  sb_set,
    input  logic [ADDR_WIDTH-1:0] sb_rd,
    output logic [DEPTH-1:0]      busy,
    output logic [ADDR_WIDTH:0]   pending
);

    localparam logic [ADDR_WIDTH-1:0] ZIDX = ADDR_WIDTH'(ZERO_IDX);

    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [ADDR_WIDTH:0] pending_q, pending_d;
    logic                set_ok;

    assign set_ok = sb_set && !(ZERO_REG && (sb_rd == ZIDX));

    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[rd] = 1'b0;
        end
        // The set is applied after the clear so a new producer wins a collision.
        if (set_ok) begin
            busy_d[sb_rd] = 1'b1;
        end
    end

    always_comb begin
        pending_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_d = pending_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign busy    = busy_q;
    assign pending = pending_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with optional write bypass and a
// busy-bit scoreboard that raises stall for reads of not-yet-written registers.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    input  logic                  sb_set,
    input  logic [ADDR_WIDTH-1:0] sb_rd,
    output logic                  stall,
    output logic [ADDR_WIDTH:0]   pending
);

    localparam int unsigned           DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZIDX  = ADDR_WIDTH'(ZERO_IDX);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  rd_zero, wen;
    logic                  fwd_a, fwd_b;
    logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

    assign rd_zero = ZERO_REG && (rd == ZIDX);
    assign wen     = we && !rd_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wen) begin
            mem_q[rd] <= data;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .we      (wen),
        .rd      (rd),
        .sb_set  (sb_set),
        .sb_rd   (sb_rd),
        .busy    (busy),
        .pending (pending)
    );

    assign fwd_a = BYPASS && wen && (rd == rs);
    assign fwd_b = BYPASS && wen && (rd == rt);

    assign rdata_a = (ZERO_REG && (rs == ZIDX)) ? '0 : mem_q[rs];
    assign rdata_b = (ZERO_REG && (rt == ZIDX)) ? '0 : mem_q[rt];

    // Forwarded data is masked during reset so the read ports read zero.
    always_comb begin
        a = '0;
        b = '0;
        if (!rst) begin
            a = fwd_a ? data : rdata_a;
            b = fwd_b ? data : rdata_b;
        end
    end

    assign stall = !rst && ((busy[rs] && !fwd_a) || (busy[rt] && !fwd_b));

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then random traffic
// against an array-based reference model, on a bypassing and a non-bypassing copy.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  rs, rt;
    logic [31:0] a, b, a0, b0;
    logic        sb_set;
    logic [4:0]  sb_rd;
    logic        stall, stall0;
    logic [5:0]  pending, pending0;

    int ntests = 0;
    int nfail  = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk (clk), .rst (rst), .we (we), .rd (rd), .data (data),
        .rs (rs), .rt (rt), .a (a), .b (b),
        .sb_set (sb_set), .sb_rd (sb_rd), .stall (stall), .pending (pending)
    );

    regfile_sb #(.BYPASS(1'b0)) dut_nb (
        .clk (clk), .rst (rst), .we (we), .rd (rd), .data (data),
        .rs (rs), .rt (rt), .a (a0), .b (b0),
        .sb_set (sb_set), .sb_rd (sb_rd), .stall (stall0), .pending (pending0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx, input bit byp);
        if (idx == 0) return 32'd0;
        if (rst) return 32'd0;
        if (byp && we && rd == idx) return data;
        return m_regs[idx];
    endfunction

    function automatic bit m_stall(input bit byp);
        bit sa, sbb;
        if (rst) return 1'b0;
        sa  = m_busy[rs] && !(byp && we && rd == rs && rd != 0);
        sbb = m_busy[rt] && !(byp && we && rd == rt && rd != 0);
        return sa || sbb;
    endfunction

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply the architectural effect of the current inputs, then take the edge.
    task automatic tick();
        if (!rst) begin
            if (we && rd != 0) begin
                m_regs[rd] = data;
                m_busy[rd] = 1'b0;
            end
            if (sb_set && sb_rd != 0) m_busy[sb_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a"},        a,                     m_read(rs, 1'b1));
        check({tag, ".b"},        b,                     m_read(rt, 1'b1));
        check({tag, ".stall"},    32'(stall),            32'(m_stall(1'b1)));
        check({tag, ".pending"},  32'(pending),          32'(m_pending()));
        check({tag, ".a_nb"},     a0,                    m_read(rs, 1'b0));
        check({tag, ".b_nb"},     b0,                    m_read(rt, 1'b0));
        check({tag, ".stall_nb"}, 32'(stall0),           32'(m_stall(1'b0)));
    endtask

    task automatic idle();
        we = 0; rd = 0; data = 0; sb_set = 0; sb_rd = 0;
    endtask

    initial begin
        rst = 1'b1; rs = 0; rt = 0;
        idle();
        m_reset();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_all("reset_init");

        // Asynchronous reset with prior contents and busy marks
        we = 1; rd = 1; data = 32'h1111; tick();
        rd = 2; data = 32'h2222; sb_set = 1; sb_rd = 3; tick();
        idle(); rs = 1; rt = 2;
        #1;
        check("prefill.a", a, 32'h1111);
        check("prefill.pending", 32'(pending), 32'd1);
        #1;
        rst = 1'b1; we = 1; rd = 1; data = 32'hdead;
        m_reset();
        #1;
        check("async_rst.a", a, 32'd0);
        check("async_rst.b", b, 32'd0);
        check("async_rst.pending", 32'(pending), 32'd0);
        check("async_rst.stall", 32'(stall), 32'd0);
        tick();
        check("rst_ignores_we.a", a, 32'd0);
        rst = 1'b0; idle();

        // Write then read
        we = 1; rd = 1; data = 32'd2001; rs = 1; rt = 2; tick();
        rd = 2; data = 32'd4001; tick();
        we = 0; rd = 1; data = 32'd5001;
        #1;
        check("wr.a", a, 32'd2001);
        check("wr.b", b, 32'd4001);
        tick();
        check("wr_disabled.a", a, 32'd2001);

        // Zero register
        we = 1; rd = 0; data = 32'd3001; sb_set = 1; sb_rd = 0; rs = 0;
        #1;
        check("zero_nobypass.a", a, 32'd0);
        tick();
        idle();
        #1;
        check("zero.a", a, 32'd0);
        check("zero.pending", 32'(pending), 32'd0);

        // Bypass vs. no bypass
        we = 1; rd = 6; data = 32'h77; tick();
        rd = 6; data = 32'd5001; rs = 6;
        #1;
        check("bypass.a", a, 32'd5001);
        check("nobypass.a", a0, 32'h77);
        tick();
        idle();
        #1;
        check("nobypass_after.a", a0, 32'd5001);

        // Scoreboard set, then clear by writeback
        sb_set = 1; sb_rd = 8; tick();
        idle(); rs = 8; rt = 1;
        #1;
        check("sb.pending", 32'(pending), 32'd1);
        check("sb.stall", 32'(stall), 32'd1);
        we = 1; rd = 8; data = 32'd3001;
        #1;
        check("sb_fwd.stall", 32'(stall), 32'd0);
        check("sb_fwd.stall_nb", 32'(stall0), 32'd1);
        check("sb_fwd.a", a, 32'd3001);
        tick();
        idle();
        #1;
        check("sb_clr.pending", 32'(pending), 32'd0);
        check("sb_clr.stall", 32'(stall), 32'd0);
        check("sb_clr.a", a, 32'd3001);

        // Collision: set and write to the same busy index
        sb_set = 1; sb_rd = 8; tick();
        sb_set = 1; sb_rd = 8; we = 1; rd = 8; data = 32'h4040; tick();
        idle();
        #1;
        check("coll.pending", 32'(pending), 32'd1);
        check("coll.stall", 32'(stall), 32'd1);
        check("coll.a", a, 32'h4040);
        sb_set = 1; sb_rd = 8; tick();
        idle();
        #1;
        check("dbl_set.pending", 32'(pending), 32'd1);

        // Random traffic on a narrow index range to force collisions
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2;
                rst = 1'b1;
                m_reset();
                #1;
                check_all("mid_rst");
                tick();
                rst = 1'b0;
            end
            we     = ($urandom_range(0, 1) == 1);
            rd     = 5'($urandom_range(0, 11));
            data   = $urandom;
            sb_set = ($urandom_range(0, 2) == 0);
            sb_rd  = 5'($urandom_range(0, 11));
            rs     = 5'($urandom_range(0, 11));
            rt     = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 11));
            #1;
            check_all("rand");
            tick();
        end
        idle();
        #1;
        check_all("final");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
